alu_seq: RTL and testbench
==========================

Name: alu_seq

Overview:
Parametrised, registered ALU for the datapath, and the next generation of the 8-bit add/subtract ALU.
- Generalised to WIDTH bits.
- Adds logic, shift and multi-cycle multiply operations.
- Adds a 4-flag register (carry, zero, negative, overflow).
- Adds a START/BUSY/DONE handshake so the controller can sequence multi-cycle ops.
- Result drives the shared bus only when output-enabled.

Parameters:
WIDTH, 8, operand/result width in bits; legal range 4..32.

Ports:
CLK  input  1  clock; all state changes on the rising edge.
CLR  input  1  reset, synchronous, active-high.
A  input  WIDTH  operand A; sampled only on the START edge.
B  input  WIDTH  operand B; sampled only on the START edge.
OP  input  3  operation select; sampled only on the START edge.
START  input  1  begin an operation; ignored while BUSY=1.
FI  input  1  flag-update enable; active-high; sampled on the START edge.
EO  input  1  bus output enable; active-high; combinational.
BUS  output  WIDTH  EO ? R : 0.
BUS_EN  output  1  equals EO; bus mux select.
CF  output  1  carry flag (registered).
ZF  output  1  zero flag (registered).
NF  output  1  negative flag (registered).
VF  output  1  signed-overflow flag (registered).
BUSY  output  1  high while a multiply is iterating.
DONE  output  1  one-cycle pulse: R and flags valid.

Behaviour:
- Reset (CLR=1 at an edge, overrides everything):
  - R=0; CF=ZF=NF=VF=0; BUSY=0; DONE=0; state=IDLE; multiply counter and accumulators = 0.
  - CLR during a multiply aborts it; the result is discarded.
- OP encoding:
  - 000 ADD, A+B.
  - 001 SUB, A+~B+1.
  - 010 AND, 011 OR, 100 XOR.
  - 101 SHL, A<<1, LSB fill 0.
  - 110 SHR, logical A>>1, MSB fill 0.
  - 111 MUL, low WIDTH bits of unsigned A*B.
- States: IDLE and MUL. DONE is a registered pulse, not a state.
- IDLE with START=1 and OP!=111 (single-cycle op):
  - On that edge (E0): R <= result; flags update if FI=1.
  - DONE=1 for exactly the cycle after E0. BUSY stays 0.
- IDLE with START=1 and OP=111:
  - On E0: latch A, B and FI; clear the accumulator; counter=0; go to MUL; BUSY=1.
  - Edges E1..EWIDTH: one shift-and-add step each, over the full 2*WIDTH product.
  - On EWIDTH: R <= product[WIDTH-1:0]; flags update if FI was 1; return to IDLE; BUSY=0; DONE=1 for the next cycle.
  - BUSY is high for exactly WIDTH cycles.
- START while BUSY=1: ignored, with no effect on the operation in progress.
- Back-to-back single-cycle ops: START on consecutive edges is accepted; DONE stays high continuously.
- Flag rules (applied only when update is enabled, else all four hold):
  - ZF = (R==0); NF = R[WIDTH-1] for every op.
  - CF:
    - ADD: carry-out.
    - SUB: carry-out of A+~B+1, i.e. 1 = no borrow.
    - SHL: A[WIDTH-1]. SHR: A[0].
    - MUL: 1 if product[2W-1:W] != 0.
    - Logic ops: 0.
  - VF:
    - ADD: signed overflow (A,B same sign, R differs).
    - SUB: A,~B same sign, R differs.
    - All other ops: 0.
- R holds its value between operations. BUS reflects R whenever EO=1, including while BUSY (BUS shows the previous R).

Test Plan:
1. WIDTH=8, FI=1, EO=1: ADD 0xF0+0x20 -> DONE next cycle; BUS=0x10; CF=1, ZF=0, NF=0, VF=0.
2. SUB 0x05-0x05 -> R=0x00, ZF=1, CF=1. Then SUB 0x03-0x05 -> R=0xFE, CF=0, NF=1. Then ADD 0x7F+0x01 -> R=0x80, VF=1, NF=1.
3. MUL 0x12*0x0E:
   - BUSY high for exactly 8 cycles; R=0xFC; CF=0; DONE one cycle.
   - START pulsed mid-BUSY -> no effect.
   - MUL 0x10*0x20 -> R=0x00, CF=1, ZF=1.
4. SHL 0x81 -> R=0x02, CF=1. SHR 0x01 -> R=0x00, CF=1, ZF=1. AND 0xF0&0x0F -> R=0x00, CF=0, ZF=1.
5. FI=0 with ADD 0xFF+0x01 -> R=0x00 but flags keep their prior values. EO=0 -> BUS=0x00 and BUS_EN=0 regardless of R.
6. CLR asserted on the 4th MUL iteration -> at the next edge R=0, all flags=0, BUSY=0, DONE=0. A following ADD 0x01+0x01 -> R=0x02.

Source files
------------

// File: rtl/alu_seq.sv
// Registered WIDTH-bit ALU with a flag register, a shift-and-add multiplier and a
// START/BUSY/DONE handshake. The result drives the shared bus only while EO is high.
module alu_seq #(
    parameter int unsigned WIDTH = 8
) (
    input  logic             CLK,
    input  logic             CLR,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic [2:0]       OP,
    input  logic             START,
    input  logic             FI,
    input  logic             EO,
    output logic [WIDTH-1:0] BUS,
    output logic             BUS_EN,
    output logic             CF,
    output logic             ZF,
    output logic             NF,
    output logic             VF,
    output logic             BUSY,
    output logic             DONE
);

    localparam int unsigned CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    typedef enum logic [2:0] {
        OP_ADD = 3'b000,
        OP_SUB = 3'b001,
        OP_AND = 3'b010,
        OP_OR  = 3'b011,
        OP_XOR = 3'b100,
        OP_SHL = 3'b101,
        OP_SHR = 3'b110,
        OP_MUL = 3'b111
    } op_t;

    typedef enum logic {
        IDLE,
        MUL
    } state_t;

    state_t             state, state_nxt;
    logic [WIDTH-1:0]   r, r_nxt;
    logic               cf, cf_nxt;
    logic               zf, zf_nxt;
    logic               nf, nf_nxt;
    logic               vf, vf_nxt;
    logic               done, done_nxt;
    logic [CW-1:0]      cnt, cnt_nxt;
    logic [2*WIDTH-1:0] mcand, mcand_nxt;
    logic [WIDTH-1:0]   mplier, mplier_nxt;
    logic [2*WIDTH-1:0] acc, acc_nxt;
    logic               fi_mul, fi_mul_nxt;

    op_t                op;
    logic [WIDTH-1:0]   b_eff;
    logic               cin;
    logic [WIDTH:0]     sum;
    logic [WIDTH-1:0]   alu_r;
    logic               alu_c;
    logic               alu_v;
    logic [2*WIDTH-1:0] step_acc;
    logic               last_step;

    // Single-cycle datapath; SUB reuses the adder as A + ~B + 1.
    always_comb begin
        op    = op_t'(OP);
        b_eff = (op == OP_SUB) ? ~B : B;
        cin   = (op == OP_SUB);
        sum   = {1'b0, A} + {1'b0, b_eff} + {{WIDTH{1'b0}}, cin};
        alu_r = '0;
        alu_c = 1'b0;
        alu_v = 1'b0;
        unique case (op)
            OP_ADD, OP_SUB: begin
                alu_r = sum[WIDTH-1:0];
                alu_c = sum[WIDTH];
                alu_v = (A[WIDTH-1] == b_eff[WIDTH-1]) &&
                        (sum[WIDTH-1] != A[WIDTH-1]);
            end
            OP_AND: alu_r = A & B;
            OP_OR:  alu_r = A | B;
            OP_XOR: alu_r = A ^ B;
            OP_SHL: begin
                alu_r = {A[WIDTH-2:0], 1'b0};
                alu_c = A[WIDTH-1];
            end
            OP_SHR: begin
                alu_r = {1'b0, A[WIDTH-1:1]};
                alu_c = A[0];
            end
            OP_MUL: begin
                alu_r = '0;
            end
            default: begin
                alu_r = '0;
            end
        endcase
    end

    // One shift-and-add step over the full double-width product.
    always_comb begin
        step_acc  = mplier[0] ? (acc + mcand) : acc;
        last_step = (cnt == CW'(WIDTH - 1));
    end

    always_comb begin
        state_nxt  = state;
        r_nxt      = r;
        cf_nxt     = cf;
        zf_nxt     = zf;
        nf_nxt     = nf;
        vf_nxt     = vf;
        done_nxt   = 1'b0;
        cnt_nxt    = cnt;
        mcand_nxt  = mcand;
        mplier_nxt = mplier;
        acc_nxt    = acc;
        fi_mul_nxt = fi_mul;

        unique case (state)
            IDLE: begin
                if (START) begin
                    if (op == OP_MUL) begin
                        state_nxt  = MUL;
                        mcand_nxt  = {{WIDTH{1'b0}}, A};
                        mplier_nxt = B;
                        acc_nxt    = '0;
                        cnt_nxt    = '0;
                        fi_mul_nxt = FI;
                    end else begin
                        r_nxt    = alu_r;
                        done_nxt = 1'b1;
                        if (FI) begin
                            cf_nxt = alu_c;
                            zf_nxt = (alu_r == '0);
                            nf_nxt = alu_r[WIDTH-1];
                            vf_nxt = alu_v;
                        end
                    end
                end
            end
            MUL: begin
                acc_nxt    = step_acc;
                mcand_nxt  = mcand << 1;
                mplier_nxt = mplier >> 1;
                cnt_nxt    = cnt + CW'(1);
                if (last_step) begin
                    state_nxt = IDLE;
                    r_nxt     = step_acc[WIDTH-1:0];
                    done_nxt  = 1'b1;
                    if (fi_mul) begin
                        cf_nxt = |step_acc[2*WIDTH-1:WIDTH];
                        zf_nxt = (step_acc[WIDTH-1:0] == '0);
                        nf_nxt = step_acc[WIDTH-1];
                        vf_nxt = 1'b0;
                    end
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    always_ff @(posedge CLK) begin
        if (CLR) begin
            state  <= IDLE;
            r      <= '0;
            cf     <= 1'b0;
            zf     <= 1'b0;
            nf     <= 1'b0;
            vf     <= 1'b0;
            done   <= 1'b0;
            cnt    <= '0;
            mcand  <= '0;
            mplier <= '0;
            acc    <= '0;
            fi_mul <= 1'b0;
        end else begin
            state  <= state_nxt;
            r      <= r_nxt;
            cf     <= cf_nxt;
            zf     <= zf_nxt;
            nf     <= nf_nxt;
            vf     <= vf_nxt;
            done   <= done_nxt;
            cnt    <= cnt_nxt;
            mcand  <= mcand_nxt;
            mplier <= mplier_nxt;
            acc    <= acc_nxt;
            fi_mul <= fi_mul_nxt;
        end
    end

    always_comb begin
        BUS    = EO ? r : '0;
        BUS_EN = EO;
        CF     = cf;
        ZF     = zf;
        NF     = nf;
        VF     = vf;
        BUSY   = (state == MUL);
        DONE   = done;
    end

endmodule

// File: tb/tb_alu_seq.sv
// Directed bench for alu_seq at WIDTH=8: table of single-cycle ops plus
// hand-written multiply, back-to-back, bus-enable and mid-multiply reset sequences.
module tb_alu_seq;

    logic       CLK = 1'b0;
    logic       CLR;
    logic [7:0] A;
    logic [7:0] B;
    logic [2:0] OP;
    logic       START;
    logic       FI;
    logic       EO;
    logic [7:0] BUS;
    logic       BUS_EN;
    logic       CF;
    logic       ZF;
    logic       NF;
    logic       VF;
    logic       BUSY;
    logic       DONE;

    int n_checks = 0;
    int n_fail   = 0;

    alu_seq #(.WIDTH(8)) dut (
        .CLK   (CLK),
        .CLR   (CLR),
        .A     (A),
        .B     (B),
        .OP    (OP),
        .START (START),
        .FI    (FI),
        .EO    (EO),
        .BUS   (BUS),
        .BUS_EN(BUS_EN),
        .CF    (CF),
        .ZF    (ZF),
        .NF    (NF),
        .VF    (VF),
        .BUSY  (BUSY),
        .DONE  (DONE)
    );

    always #5 CLK = ~CLK;

    typedef struct {
        logic [2:0] op;
        logic [7:0] a;
        logic [7:0] b;
        logic       fi;
        logic [7:0] r;
        logic [3:0] f;   // {C,Z,N,V}
    } vec_t;

    vec_t vecs[11];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic check_flags(input string name, input logic [3:0] exp);
        check(name, {28'd0, CF, ZF, NF, VF}, {28'd0, exp});
    endtask

    // Launch a single-cycle op and sample in the DONE cycle.
    task automatic run_single(input logic [2:0] op, input logic [7:0] a, input logic [7:0] b,
                              input logic fi);
        @(negedge CLK);
        OP = op; A = a; B = b; FI = fi; START = 1'b1;
        @(negedge CLK);
        START = 1'b0;
    endtask

    // Launch a multiply and count BUSY cycles; optionally pulse START mid-run.
    task automatic run_mul(input logic [7:0] a, input logic [7:0] b, input logic poke,
                           input logic [7:0] prev_r, output int busy_cycles);
        int guard;
        @(negedge CLK);
        OP = 3'b111; A = a; B = b; FI = 1'b1; START = 1'b1;
        @(negedge CLK);
        START = 1'b0;
        busy_cycles = 0;
        guard = 0;
        while (BUSY === 1'b1 && guard < 20) begin
            busy_cycles++;
            guard++;
            if (busy_cycles == 2) check("mul_bus_prev_r", {24'd0, BUS}, {24'd0, prev_r});
            if (busy_cycles == 3) check("mul_done_low", {31'd0, DONE}, 32'd0);
            if (poke && busy_cycles == 3) begin
                OP = 3'b000; A = 8'h01; B = 8'h01; START = 1'b1;
            end else begin
                START = 1'b0;
            end
            @(negedge CLK);
        end
        START = 1'b0;
    endtask

    initial begin
        int bc;

        vecs[0]  = '{3'b000, 8'hF0, 8'h20, 1'b1, 8'h10, 4'b1000};
        vecs[1]  = '{3'b001, 8'h05, 8'h05, 1'b1, 8'h00, 4'b1100};
        vecs[2]  = '{3'b001, 8'h03, 8'h05, 1'b1, 8'hFE, 4'b0010};
        vecs[3]  = '{3'b000, 8'h7F, 8'h01, 1'b1, 8'h80, 4'b0011};
        vecs[4]  = '{3'b101, 8'h81, 8'h00, 1'b1, 8'h02, 4'b1000};
        vecs[5]  = '{3'b110, 8'h01, 8'h00, 1'b1, 8'h00, 4'b1100};
        vecs[6]  = '{3'b010, 8'hF0, 8'h0F, 1'b1, 8'h00, 4'b0100};
        vecs[7]  = '{3'b011, 8'hA0, 8'h05, 1'b1, 8'hA5, 4'b0010};
        vecs[8]  = '{3'b100, 8'hFF, 8'h0F, 1'b1, 8'hF0, 4'b0010};
        vecs[9]  = '{3'b000, 8'hFF, 8'h01, 1'b0, 8'h00, 4'b0010};  // FI=0: flags hold
        vecs[10] = '{3'b001, 8'h80, 8'h01, 1'b1, 8'h7F, 4'b1001};

        CLR = 1'b1; A = '0; B = '0; OP = '0; START = 1'b0; FI = 1'b1; EO = 1'b1;
        repeat (3) @(negedge CLK);
        check("rst_bus", {24'd0, BUS}, 32'd0);
        check_flags("rst_flags", 4'b0000);
        check("rst_busy_done", {30'd0, BUSY, DONE}, 32'd0);
        CLR = 1'b0;

        foreach (vecs[i]) begin
            run_single(vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].fi);
            check($sformatf("vec%0d_done", i), {31'd0, DONE}, 32'd1);
            check($sformatf("vec%0d_busy", i), {31'd0, BUSY}, 32'd0);
            check($sformatf("vec%0d_r", i), {24'd0, BUS}, {24'd0, vecs[i].r});
            check_flags($sformatf("vec%0d_flags", i), vecs[i].f);
            @(negedge CLK);
            check($sformatf("vec%0d_done_pulse", i), {31'd0, DONE}, 32'd0);
        end

        // Output enable gating; R is 0x7F here.
        EO = 1'b0;
        #1;
        check("eo0_bus", {24'd0, BUS}, 32'd0);
        check("eo0_bus_en", {31'd0, BUS_EN}, 32'd0);
        EO = 1'b1;
        #1;
        check("eo1_bus", {24'd0, BUS}, 32'h7F);
        check("eo1_bus_en", {31'd0, BUS_EN}, 32'd1);

        // Back-to-back single-cycle ops keep DONE high.
        @(negedge CLK);
        OP = 3'b000; A = 8'h01; B = 8'h02; FI = 1'b1; START = 1'b1;
        @(negedge CLK);
        A = 8'h03; B = 8'h04;
        check("b2b_done1", {31'd0, DONE}, 32'd1);
        check("b2b_r1", {24'd0, BUS}, 32'h03);
        @(negedge CLK);
        START = 1'b0;
        check("b2b_done2", {31'd0, DONE}, 32'd1);
        check("b2b_r2", {24'd0, BUS}, 32'h07);
        @(negedge CLK);
        check("b2b_done_off", {31'd0, DONE}, 32'd0);

        // Multiply with a START poke mid-run; previous R is 0x07.
        run_mul(8'h12, 8'h0E, 1'b1, 8'h07, bc);
        check("mul1_busy_cycles", bc, 32'd8);
        check("mul1_done", {31'd0, DONE}, 32'd1);
        check("mul1_r", {24'd0, BUS}, 32'hFC);
        check_flags("mul1_flags", 4'b0010);
        @(negedge CLK);
        check("mul1_done_pulse", {31'd0, DONE}, 32'd0);
        check("mul1_poke_ignored", {24'd0, BUS}, 32'hFC);

        run_mul(8'h10, 8'h20, 1'b0, 8'hFC, bc);
        check("mul2_busy_cycles", bc, 32'd8);
        check("mul2_r", {24'd0, BUS}, 32'h00);
        check_flags("mul2_flags", 4'b1100);

        // Reset during the 4th multiply iteration aborts it.
        @(negedge CLK);
        OP = 3'b111; A = 8'h12; B = 8'h0E; FI = 1'b1; START = 1'b1;
        @(negedge CLK);
        START = 1'b0;
        repeat (2) @(negedge CLK);
        check("clr_pre_busy", {31'd0, BUSY}, 32'd1);
        CLR = 1'b1;
        @(negedge CLK);
        CLR = 1'b0;
        check("clr_bus", {24'd0, BUS}, 32'd0);
        check_flags("clr_flags", 4'b0000);
        check("clr_busy_done", {30'd0, BUSY, DONE}, 32'd0);
        repeat (10) @(negedge CLK);
        check("clr_stays_idle", {30'd0, BUSY, DONE}, 32'd0);

        run_single(3'b000, 8'h01, 8'h01, 1'b1);
        check("post_clr_add_r", {24'd0, BUS}, 32'h02);
        check_flags("post_clr_add_flags", 4'b0000);
        check("post_clr_add_done", {31'd0, DONE}, 32'd1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

endmodule
